// File: rtl/game_master_fsm_multi_torpedo_pkg.sv
// Shared definitions for the multi-torpedo game master: state encoding
// and default parameter values used by the FSM and its allocator.
package game_master_fsm_multi_torpedo_pkg;

  typedef enum logic [2:0] {
    ST_START    = 3'd0,
    ST_ROUND    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_WON      = 3'd3,
    ST_WON_END  = 3'd4,
    ST_LOST     = 3'd5,
    ST_LOST_END = 3'd6
  } state_t;

  localparam int DEF_N_TORPEDOES = 2;
  localparam int DEF_LIVES       = 3;
  localparam int DEF_WIN_SCORE   = 5;
  localparam int DEF_SCORE_W     = 4;

endpackage

// File: rtl/game_master_fsm_multi_torpedo_allocator.sv
// Torpedo allocator: picks the lowest-index idle torpedo when a launch is
// requested. Purely combinational; grant is one-hot or all zero.
module game_torpedo_allocator #(
  parameter int N_TORPEDOES = 2
) (
  input  logic [N_TORPEDOES-1:0] inflight,
  input  logic                   launch,
  output logic [N_TORPEDOES-1:0] grant,
  output logic                   grant_valid
);

  // Scan from index 0 upward; the first idle torpedo wins the launch.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < N_TORPEDOES; i++) begin
      if (launch && !inflight[i] && !grant_valid) begin
        grant[i]    = 1'b1;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_master_fsm_multi_torpedo.sv
// Game master FSM for one target sprite and a pool of torpedo sprites.
// Tracks score and lives across rounds and ends the game on a win score
// or when the lives run out, handing off to the end-of-game timer.
module game_master_fsm_multi_torpedo
  import game_master_fsm_multi_torpedo_pkg::*;
#(
  parameter int N_TORPEDOES = DEF_N_TORPEDOES,
  parameter int LIVES       = DEF_LIVES,
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int SCORE_W     = DEF_SCORE_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key,
  output logic                   sprite_target_write_xy,
  output logic                   sprite_target_write_dxy,
  output logic                   sprite_target_enable_update,
  output logic [N_TORPEDOES-1:0] sprite_torpedo_write_xy,
  output logic [N_TORPEDOES-1:0] sprite_torpedo_write_dxy,
  output logic [N_TORPEDOES-1:0] sprite_torpedo_enable_update,
  input  logic                   sprite_target_within_screen,
  input  logic [N_TORPEDOES-1:0] sprite_torpedo_within_screen,
  input  logic [N_TORPEDOES-1:0] collision,
  output logic                   end_of_game_timer_start,
  output logic                   game_won,
  input  logic                   end_of_game_timer_running,
  output logic [SCORE_W-1:0]     score,
  output logic [3:0]             lives_left
);

  state_t                   state, state_d;
  logic                     key_q;
  logic [N_TORPEDOES-1:0]   inflight, inflight_d;
  logic [SCORE_W-1:0]       score_d;
  logic [3:0]               lives_d;

  logic                     launch;
  logic                     hit;
  logic                     escape;
  logic                     launch_req;
  logic [N_TORPEDOES-1:0]   miss;
  logic [N_TORPEDOES-1:0]   grant;
  logic                     grant_valid;
  logic [SCORE_W-1:0]       score_inc;

  // Event decode: rising key edge, hits and misses only count for torpedoes in flight.
  assign launch     = key & ~key_q;
  assign hit        = |(collision & inflight);
  assign escape     = ~sprite_target_within_screen;
  assign miss       = inflight & ~sprite_torpedo_within_screen;
  assign score_inc  = score + 1'b1;
  // A launch is only honoured in PLAY when no round-ending event is pending.
  assign launch_req = launch & (state == ST_PLAY) & ~hit & ~escape;

  game_torpedo_allocator #(
    .N_TORPEDOES (N_TORPEDOES)
  ) u_alloc (
    .inflight    (inflight),
    .launch      (launch_req),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // State, key history, flight mask, score and lives registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_START;
      key_q      <= 1'b0;
      inflight   <= '0;
      score      <= '0;
      lives_left <= 4'(LIVES);
    end else begin
      state      <= state_d;
      key_q      <= key;
      inflight   <= inflight_d;
      score      <= score_d;
      lives_left <= lives_d;
    end
  end

  // Next-state logic, register updates and sprite/timer control outputs.
  always_comb begin
    state_d                      = state;
    inflight_d                   = inflight;
    score_d                      = score;
    lives_d                      = lives_left;
    sprite_target_write_xy       = 1'b0;
    sprite_target_write_dxy      = 1'b0;
    sprite_target_enable_update  = 1'b0;
    sprite_torpedo_write_xy      = '0;
    sprite_torpedo_write_dxy     = '0;
    sprite_torpedo_enable_update = '0;
    end_of_game_timer_start      = 1'b0;
    game_won                     = 1'b0;

    case (state)
      ST_START: begin
        sprite_target_write_xy   = 1'b1;
        sprite_target_write_dxy  = 1'b1;
        sprite_torpedo_write_xy  = '1;
        sprite_torpedo_write_dxy = '1;
        score_d                  = '0;
        lives_d                  = 4'(LIVES);
        inflight_d               = '0;
        state_d                  = ST_PLAY;
      end

      ST_ROUND: begin
        sprite_target_write_xy   = 1'b1;
        sprite_target_write_dxy  = 1'b1;
        sprite_torpedo_write_xy  = '1;
        sprite_torpedo_write_dxy = '1;
        inflight_d               = '0;
        state_d                  = ST_PLAY;
      end

      ST_PLAY: begin
        sprite_target_enable_update  = 1'b1;
        sprite_torpedo_enable_update = inflight;
        if (hit) begin
          // Simultaneous hits count once; reaching WIN_SCORE ends the game.
          score_d = score_inc;
          state_d = (score_inc == SCORE_W'(WIN_SCORE)) ? ST_WON : ST_ROUND;
        end else if (escape) begin
          if (lives_left == 4'd1) begin
            lives_d = 4'd0;
            state_d = ST_LOST;
          end else begin
            lives_d = lives_left - 4'd1;
            state_d = ST_ROUND;
          end
        end else begin
          // Misses reload their torpedo; a launch may use a different idle slot.
          sprite_torpedo_write_xy  = miss;
          sprite_torpedo_write_dxy = grant;
          inflight_d               = inflight & ~miss;
          if (grant_valid) begin
            inflight_d = inflight_d | grant;
          end
        end
      end

      ST_WON: begin
        end_of_game_timer_start = 1'b1;
        game_won                = 1'b1;
        state_d                 = ST_WON_END;
      end

      ST_WON_END: begin
        game_won = 1'b1;
        if (!end_of_game_timer_running) begin
          state_d = ST_START;
        end
      end

      ST_LOST: begin
        end_of_game_timer_start = 1'b1;
        state_d                 = ST_LOST_END;
      end

      ST_LOST_END: begin
        if (!end_of_game_timer_running) begin
          state_d = ST_START;
        end
      end

      default: begin
        state_d = ST_START;
      end
    endcase
  end

endmodule
